// File: rtl/mmm_pkg.sv
// mmm_pkg: shared state encoding, FP16 field widths and default sizing for the MMM sequencer
package mmm_pkg;
  typedef enum logic [2:0] {IDLE, CLEAR, FEED, FLUSH, DRAIN, DONE} state_t;
  typedef struct packed {
    logic busy;
    logic done;
    logic err;
    logic rd;
    logic we;
    logic mux;
    logic res;
  } ctl_t;
  localparam int SIGN_W = 1;
  localparam int EXP_W = 5;
  localparam int FRAC_W = 10;
  localparam int DW = SIGN_W + EXP_W + FRAC_W;
  localparam int N_DEF = 4;
  localparam int K_MAX_DEF = 16;
  function automatic logic k_ok(input int k, input int k_max);
    return k >= 1 && k <= k_max;
  endfunction
endpackage

// File: rtl/mmm_ctrl_if.sv
// mmm_ctrl_if: host/array control bundle of the MMM sequencer; abort/aborted exist only with MMM_CTRL_ABORT_EN
interface mmm_ctrl_if #(
  parameter int N = 4,
  parameter int AW = 4,
  parameter int KW = 5
);
  localparam int RW = $clog2(N);
  logic start;
  logic [KW-1:0] k_len;
  logic busy;
  logic done;
  logic err;
  logic a_rd_en;
  logic [AW-1:0] a_rd_addr;
  logic b_rd_en;
  logic [AW-1:0] b_rd_addr;
  logic [N-1:0] row_valid;
  logic [N-1:0] col_valid;
  logic pe_we;
  logic pe_mux;
  logic res_valid;
  logic [RW-1:0] res_row;
`ifdef MMM_CTRL_ABORT_EN
  logic abort;
  logic aborted;
  modport master(output start, k_len, abort, input busy, done, err, a_rd_en, a_rd_addr, b_rd_en, b_rd_addr,
                 row_valid, col_valid, pe_we, pe_mux, res_valid, res_row, aborted);
  modport slave(input start, k_len, abort, output busy, done, err, a_rd_en, a_rd_addr, b_rd_en, b_rd_addr,
                row_valid, col_valid, pe_we, pe_mux, res_valid, res_row, aborted);
`else
  modport master(output start, k_len, input busy, done, err, a_rd_en, a_rd_addr, b_rd_en, b_rd_addr,
                 row_valid, col_valid, pe_we, pe_mux, res_valid, res_row);
  modport slave(input start, k_len, output busy, done, err, a_rd_en, a_rd_addr, b_rd_en, b_rd_addr,
                row_valid, col_valid, pe_we, pe_mux, res_valid, res_row);
`endif
endinterface

// File: rtl/mmm_skew.sv
// mmm_skew: N-lane triangular delay line, lane i delayed by i cycles, synchronous clear
module mmm_skew #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         clr,
  input  logic [N-1:0] din,
  output logic [N-1:0] dout
);
  assign dout[0] = din[0];
  for (genvar i = 1; i < N; i++) begin : g_lane
    logic [i-1:0] sr;
    logic [i:0] nx;
    assign nx = {sr, din[i]};
    assign dout[i] = nx[i];
    // shift this lane's valid one stage per cycle, dropped on clear
    always_ff @(posedge clk) sr <= clr ? '0 : nx[i-1:0];
  end
endmodule

// File: rtl/mmm_ctrl.sv
// mmm_ctrl: systolic-array sequencer (clear, feed, flush, drain); optional abort via MMM_CTRL_ABORT_EN
module mmm_ctrl
  import mmm_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int K_MAX = K_MAX_DEF,
  parameter int AW = 4,
  parameter int KW = 5
) (
  input logic clk,
  input logic reset,
  mmm_ctrl_if.slave bus
);
  localparam int RW = $clog2(N);
  state_t st;
  ctl_t ctl;
  logic [KW-1:0] k_reg;
  logic [KW-1:0] cnt;
  logic [AW-1:0] addr;
  logic [RW-1:0] row;
  logic feed_v;
  logic clr;
`ifdef MMM_CTRL_ABORT_EN
  logic aborted;
  logic abort_hit;
  assign abort_hit = bus.abort && st != IDLE;
  assign clr = reset || abort_hit;
  assign bus.aborted = aborted;
`else
  assign clr = reset;
`endif
  assign bus.busy = ctl.busy;
  assign bus.done = ctl.done;
  assign bus.err = ctl.err;
  assign bus.a_rd_en = ctl.rd;
  assign bus.b_rd_en = ctl.rd;
  assign bus.a_rd_addr = addr;
  assign bus.b_rd_addr = addr;
  assign bus.pe_we = ctl.we;
  assign bus.pe_mux = ctl.mux;
  assign bus.res_valid = ctl.res;
  assign bus.res_row = row;
  // sequencer FSM with registered array and host outputs
  always_ff @(posedge clk)
    if (reset) begin
      st <= IDLE;
      ctl <= '0;
      k_reg <= '0;
      cnt <= '0;
      addr <= '0;
      row <= '0;
`ifdef MMM_CTRL_ABORT_EN
      aborted <= 1'b0;
    end else if (abort_hit) begin
      st <= IDLE;
      ctl <= '0;
      cnt <= '0;
      addr <= '0;
      row <= '0;
      aborted <= 1'b1;
`endif
    end else begin
`ifdef MMM_CTRL_ABORT_EN
      aborted <= 1'b0;
`endif
      ctl.done <= 1'b0;
      ctl.err <= 1'b0;
      case (st)
        IDLE:
          if (bus.start) begin
            if (k_ok(int'(bus.k_len), K_MAX)) begin
              st <= CLEAR;
              k_reg <= bus.k_len;
              ctl.busy <= 1'b1;
              ctl.we <= 1'b1;
            end else ctl.err <= 1'b1;
          end
        CLEAR: begin
          st <= FEED;
          ctl.we <= 1'b0;
          ctl.mux <= 1'b1;
          ctl.rd <= 1'b1;
          addr <= '0;
          cnt <= '0;
        end
        FEED:
          if (cnt == k_reg - 1'b1) begin
            st <= FLUSH;
            ctl.rd <= 1'b0;
            cnt <= '0;
            addr <= '0;
          end else begin
            cnt <= cnt + 1'b1;
            addr <= addr + 1'b1;
          end
        FLUSH:
          if (cnt == KW'(2 * N - 3)) begin
            st <= DRAIN;
            ctl.mux <= 1'b0;
            ctl.res <= 1'b1;
            row <= '0;
          end else cnt <= cnt + 1'b1;
        DRAIN:
          if (row == RW'(N - 1)) begin
            st <= DONE;
            ctl.res <= 1'b0;
            ctl.done <= 1'b1;
            row <= '0;
          end else row <= row + 1'b1;
        DONE: begin
          st <= IDLE;
          ctl.busy <= 1'b0;
        end
        default: st <= IDLE;
      endcase
    end
  // operand buffers answer one cycle after the read strobe
  always_ff @(posedge clk) feed_v <= clr ? 1'b0 : ctl.rd;
  mmm_skew #(.N(N)) u_row_skew (.clk(clk), .clr(clr), .din({N{feed_v}}), .dout(bus.row_valid));
  mmm_skew #(.N(N)) u_col_skew (.clk(clk), .clr(clr), .din({N{feed_v}}), .dout(bus.col_valid));
endmodule

// File: tb/tb_mmm_ctrl.sv
// tb_mmm_ctrl: scoreboard bench for mmm_ctrl (abort scenarios built when MMM_CTRL_ABORT_EN is defined)
module tb_mmm_ctrl;
  localparam int N = 4;
  localparam int K_MAX = 16;
  localparam int AW = 4;
  localparam int KW = 5;
  localparam int RW = $clog2(N);
  localparam int VW = 8 + 2 * N;
  typedef logic [VW-1:0] vec_t;

  logic clk = 1'b0;
  logic reset;
  int errors = 0;
  int checks = 0;
  int addr_q[$];
  int row_q[$];

  always #5 clk = ~clk;

  mmm_ctrl_if #(.N(N), .AW(AW), .KW(KW)) bus ();
  mmm_ctrl #(.N(N), .K_MAX(K_MAX), .AW(AW), .KW(KW)) dut (.clk(clk), .reset(reset), .bus(bus));

  function automatic vec_t obs();
    return {bus.busy, bus.done, bus.err, bus.a_rd_en, bus.b_rd_en, bus.pe_we, bus.pe_mux, bus.res_valid,
            bus.row_valid, bus.col_valid};
  endfunction

  // expected outputs t cycles after the cycle in which start was accepted
  function automatic vec_t model(input int k, input int t);
    logic [N-1:0] lane;
    logic rd;
    for (int i = 0; i < N; i++) lane[i] = (t >= 3 + i) && (t <= k + 2 + i);
    rd = (t >= 2) && (t <= k + 1);
    return {(t >= 1) && (t <= k + 3 * N), t == k + 3 * N, 1'b0, rd, rd, t == 1,
            (t >= 2) && (t <= k + 2 * N - 1), (t >= k + 2 * N) && (t <= k + 3 * N - 1), lane, lane};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b1;
    bus.k_len = KW'(3);
    repeat (2) @(negedge clk);
    checks++;
    if (obs() !== '0 || bus.a_rd_addr !== '0 || bus.res_row !== '0) begin
      errors++;
      $display("FAIL reset_held got=%h addr=%0d row=%0d exp=0", obs(), bus.a_rd_addr, bus.res_row);
    end
    reset = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    checks++;
    if (obs() !== '0 || bus.a_rd_addr !== '0 || bus.res_row !== '0) begin
      errors++;
      $display("FAIL reset_after got=%h addr=%0d row=%0d exp=0", obs(), bus.a_rd_addr, bus.res_row);
    end
  endtask

  task automatic run(input int k, input int ign1, input int ign2, input string nm);
    vec_t o, e;
    int ev;
    @(negedge clk);
    bus.start = 1'b1;
    bus.k_len = KW'(k);
    for (int a = 0; a < k; a++) addr_q.push_back(a);
    for (int r = 0; r < N; r++) row_q.push_back(r);
    for (int t = 1; t <= k + 3 * N + 1; t++) begin
      @(negedge clk);
      o = obs();
      e = model(k, t);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s ctrl t=%0d got=%h exp=%h", nm, t, o, e);
      end
      if (bus.a_rd_en === 1'b1) begin
        checks++;
        if (addr_q.size() == 0) begin
          errors++;
          $display("FAIL %s extra_beat t=%0d got=%0d exp=none", nm, t, bus.a_rd_addr);
        end else begin
          ev = addr_q.pop_front();
          if (bus.a_rd_addr !== AW'(ev) || bus.b_rd_addr !== AW'(ev)) begin
            errors++;
            $display("FAIL %s addr t=%0d got=%0d/%0d exp=%0d", nm, t, bus.a_rd_addr, bus.b_rd_addr, ev);
          end
        end
      end
      if (bus.res_valid === 1'b1) begin
        checks++;
        if (row_q.size() == 0) begin
          errors++;
          $display("FAIL %s extra_row t=%0d got=%0d exp=none", nm, t, bus.res_row);
        end else begin
          ev = row_q.pop_front();
          if (bus.res_row !== RW'(ev)) begin
            errors++;
            $display("FAIL %s res_row t=%0d got=%0d exp=%0d", nm, t, bus.res_row, ev);
          end
        end
      end
      bus.start = (t == ign1) || (t == ign2);
      bus.k_len = (t == ign2) ? KW'(0) : KW'(3);
    end
    bus.start = 1'b0;
    checks++;
    if (addr_q.size() != 0 || row_q.size() != 0) begin
      errors++;
      $display("FAIL %s leftover got=%0d/%0d exp=0/0", nm, addr_q.size(), row_q.size());
    end
    addr_q.delete();
    row_q.delete();
  endtask

  task automatic test_reject(input int k);
    @(negedge clk);
    bus.start = 1'b1;
    bus.k_len = KW'(k);
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if ({bus.err, bus.busy, bus.a_rd_en, bus.b_rd_en} !== 4'b1000) begin
      errors++;
      $display("FAIL reject_%0d err/busy/rd got=%b exp=1000", k, {bus.err, bus.busy, bus.a_rd_en, bus.b_rd_en});
    end
    @(negedge clk);
    checks++;
    if (obs() !== '0) begin
      errors++;
      $display("FAIL reject_%0d_after got=%h exp=0", k, obs());
    end
  endtask

  task automatic test_reset_mid();
    logic found;
    @(negedge clk);
    bus.start = 1'b1;
    bus.k_len = KW'(16);
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      found = bus.a_rd_en === 1'b1 && bus.a_rd_addr === AW'(2);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reset_mid_wait got=timeout exp=addr2");
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (obs() !== '0 || bus.a_rd_addr !== '0 || bus.res_row !== '0) begin
      errors++;
      $display("FAIL reset_mid got=%h addr=%0d row=%0d exp=0", obs(), bus.a_rd_addr, bus.res_row);
    end
    run(1, -1, -1, "after_reset_k1");
  endtask

`ifdef MMM_CTRL_ABORT_EN
  task automatic test_abort();
    logic found;
    int seen;
    @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    checks++;
    if (bus.aborted !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle aborted/busy got=%b%b exp=00", bus.aborted, bus.busy);
    end
    bus.start = 1'b1;
    bus.k_len = KW'(3);
    found = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      found = bus.res_valid === 1'b1 && bus.res_row === RW'(1);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL abort_wait got=timeout exp=res_row1");
    end
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    checks++;
    if ({bus.aborted, bus.res_valid, bus.busy, bus.done, bus.row_valid, bus.col_valid} !== {4'b1000, {2 * N{1'b0}}}) begin
      errors++;
      $display("FAIL abort_drain got=%b exp=1000 and lanes 0",
               {bus.aborted, bus.res_valid, bus.busy, bus.done, bus.row_valid, bus.col_valid});
    end
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.aborted === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL abort_no_done got=%0d exp=0", seen);
    end
    bus.start = 1'b1;
    bus.k_len = KW'(3);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus.abort = 1'b0;
    checks++;
    if (bus.aborted !== 1'b0 || obs() !== '0) begin
      errors++;
      $display("FAIL abort_vs_reset aborted=%b outs=%h exp=0/0", bus.aborted, obs());
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.k_len = '0;
`ifdef MMM_CTRL_ABORT_EN
    bus.abort = 1'b0;
`endif
    test_reset();
    run(3, -1, -1, "k3");
    test_reject(0);
    test_reject(17);
    run(16, 5, 15, "k16_ignore_start");
    test_reset_mid();
    run(2, -1, -1, "b2b_k2");
    run(5, -1, -1, "b2b_k5");
`ifdef MMM_CTRL_ABORT_EN
    test_abort();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
